// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch front end: FSM states and the
// layout of one fetch-queue entry.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

  localparam int unsigned FETCH_XLEN = 32;

  // Entry layout, MSB to LSB: pc, instr, fault.
  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] instr;
    logic                  fault;
  } fetch_entry_t;

  function automatic int unsigned entry_width(input int unsigned xlen);
    return 2 * xlen + 1;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small power-of-two FIFO between the fetch FSM and decode, with a
// single-cycle flush that wins over any same-cycle push or pop.
module fetch_queue #(
  parameter int unsigned ENTRY_W = 65,
  parameter int unsigned QDEPTH  = 2,
  localparam int unsigned PTR_W  = $clog2(QDEPTH),
  localparam int unsigned CNT_W  = PTR_W + 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_flush,
  input  logic               i_push,
  input  logic [ENTRY_W-1:0] i_push_data,
  input  logic               i_pop,
  output logic [ENTRY_W-1:0] o_head,
  output logic               o_valid,
  output logic [CNT_W-1:0]   o_count
);

  logic [ENTRY_W-1:0] slots [QDEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               push_ok, pop_ok;

  always_comb begin
    pop_ok   = i_pop && (count_q != '0);
    push_ok  = i_push && (count_q != CNT_W'(QDEPTH));
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointer width equals log2(QDEPTH), so increments wrap for free.
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_ok && !i_flush) slots[wr_ptr_q] <= i_push_data;
  end

  assign o_head  = slots[rd_ptr_q];
  assign o_valid = (count_q != '0);
  assign o_count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues one memory request at a time from the external
// PC counter, queues responses for decode, and handles redirects and faults.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned QDEPTH = 2
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_pc_en,
  output logic            o_pc_load,
  output logic [XLEN-1:0] o_pc_addr,
  output logic            o_mem_req_valid,
  input  logic            i_mem_req_ready,
  output logic [XLEN-1:0] o_mem_req_addr,
  input  logic            i_mem_rsp_valid,
  input  logic [XLEN-1:0] i_mem_rsp_data,
  input  logic            i_mem_rsp_err,
  output logic            o_dec_valid,
  input  logic            i_dec_ready,
  output logic [XLEN-1:0] o_dec_instr,
  output logic [XLEN-1:0] o_dec_pc,
  output logic            o_dec_fault,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc
);

  localparam int unsigned ENTRY_W = entry_width(XLEN);
  localparam int unsigned CNT_W   = $clog2(QDEPTH) + 1;

  fetch_state_e       state_q, state_d;
  logic [XLEN-1:0]    out_pc_q, out_pc_d;
  logic [CNT_W-1:0]   q_count;
  logic               q_valid;
  logic               req_valid, req_fire, rsp_take, dec_pop;
  logic [ENTRY_W-1:0] push_entry, head_entry;

  always_comb begin
    // A slot is reserved at issue time, so a response can always be pushed.
    req_valid = i_rst_n && (state_q == ST_REQ) && !i_redirect
                && (q_count < CNT_W'(QDEPTH));
    req_fire  = req_valid && i_mem_req_ready;
    rsp_take  = i_rst_n && (state_q == ST_WAIT) && i_mem_rsp_valid && !i_redirect;
    dec_pop   = i_rst_n && q_valid && i_dec_ready;
    state_d   = state_q;
    out_pc_d  = out_pc_q;
    if (req_fire) out_pc_d = i_pc;
    if (i_redirect) begin
      // An outstanding request must be drained unless its response lands now.
      case (state_q)
        ST_WAIT, ST_DRAIN: state_d = i_mem_rsp_valid ? ST_REQ : ST_DRAIN;
        default:           state_d = ST_REQ;
      endcase
    end else begin
      case (state_q)
        ST_REQ:   if (req_fire) state_d = ST_WAIT;
        ST_WAIT:  if (i_mem_rsp_valid) state_d = i_mem_rsp_err ? ST_HALT : ST_REQ;
        ST_DRAIN: if (i_mem_rsp_valid) state_d = ST_REQ;
        ST_HALT:  state_d = ST_HALT;
        default:  state_d = ST_REQ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= ST_REQ;
      out_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      out_pc_q <= out_pc_d;
    end
  end

  assign o_mem_req_valid = req_valid;
  assign o_mem_req_addr  = i_pc;
  assign o_pc_en         = i_rst_n && (i_redirect || req_fire);
  assign o_pc_load       = i_rst_n && i_redirect;
  assign o_pc_addr       = (i_rst_n && i_redirect) ? i_redirect_pc : '0;

  assign push_entry = {out_pc_q, i_mem_rsp_data, i_mem_rsp_err};

  fetch_queue #(
    .ENTRY_W (ENTRY_W),
    .QDEPTH  (QDEPTH)
  ) u_queue (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_flush     (i_redirect),
    .i_push      (rsp_take),
    .i_push_data (push_entry),
    .i_pop       (dec_pop),
    .o_head      (head_entry),
    .o_valid     (q_valid),
    .o_count     (q_count)
  );

  assign o_dec_valid = i_rst_n && q_valid;
  assign o_dec_pc    = head_entry[ENTRY_W-1 -: XLEN];
  assign o_dec_instr = head_entry[XLEN:1];
  assign o_dec_fault = head_entry[0];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: table of single-cycle control vectors plus
// scoreboarded sequences with a PC-counter and memory model around the DUT.
module tb_fetch_unit;

  localparam int QD = 2;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_r;
  logic        pc_en, pc_load;
  logic [31:0] pc_addr;
  logic        req_valid;
  logic        rdy;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr, dec_pc;
  logic        dec_fault;
  logic        redirect;
  logic [31:0] rpc;

  fetch_unit #(.XLEN(32), .QDEPTH(QD)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_pc            (pc_r),
    .o_pc_en         (pc_en),
    .o_pc_load       (pc_load),
    .o_pc_addr       (pc_addr),
    .o_mem_req_valid (req_valid),
    .i_mem_req_ready (rdy),
    .o_mem_req_addr  (req_addr),
    .i_mem_rsp_valid (rsp_valid),
    .i_mem_rsp_data  (rsp_data),
    .i_mem_rsp_err   (rsp_err),
    .o_dec_valid     (dec_valid),
    .i_dec_ready     (dec_ready),
    .o_dec_instr     (dec_instr),
    .o_dec_pc        (dec_pc),
    .o_dec_fault     (dec_fault),
    .i_redirect      (redirect),
    .i_redirect_pc   (rpc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } exp_t;

  typedef struct {
    logic        rdy;
    logic        rd;
    logic [31:0] rpc;
    logic [31:0] pc;
    logic        e_valid;
    logic        e_en;
    logic        e_load;
    logic [31:0] e_paddr;
    logic        e_next_valid;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int hs_cnt, load_cnt, dv_cnt;
  int first_hs_cyc, first_dv_cyc;
  int lat = 1;
  int pend_cnt;
  logic env_on = 1'b0;
  logic pend = 1'b0;
  logic [31:0] pend_addr;
  logic err_en = 1'b0;
  logic [31:0] err_addr = 32'h0;
  logic s_req_valid, s_pc_en, s_pc_load, s_dec_valid, s_rsp_valid, s_hs, s_pop;
  logic [31:0] s_req_addr, s_pc_addr, last_hs_addr, last_pc;
  logic last_fault;
  logic [31:0] req_log[$];
  logic [31:0] pop_log[$];
  exp_t sb[$];
  vec_t vecs[6];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: sample at negedge, score decode pops, then update the
  // PC-counter and memory models just after the rising edge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    s_req_valid = req_valid;
    s_req_addr  = req_addr;
    s_pc_en     = pc_en;
    s_pc_load   = pc_load;
    s_pc_addr   = pc_addr;
    s_dec_valid = dec_valid;
    s_rsp_valid = rsp_valid;
    s_hs        = req_valid && rdy;
    s_pop       = dec_valid && dec_ready;
    if (pc_load) load_cnt++;
    if (dec_valid) dv_cnt++;
    if (s_hs) begin
      hs_cnt++;
      last_hs_addr = req_addr;
      req_log.push_back(req_addr);
      if (first_hs_cyc < 0) first_hs_cyc = cyc;
    end
    if (dec_valid && first_dv_cyc < 0) first_dv_cyc = cyc;
    if (env_on && rst_n) begin
      if (redirect) begin
        sb.delete();
      end else if (s_pop) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL sb_unexpected: got pc %h instr %h, expected no entry", dec_pc, dec_instr);
        end else begin
          e = sb.pop_front();
          check("sb_pc", dec_pc, e.pc);
          check("sb_instr", dec_instr, e.instr);
          check("sb_fault", 32'(dec_fault), 32'(e.fault));
        end
        last_pc = dec_pc;
        last_fault = dec_fault;
        pop_log.push_back(dec_pc);
      end
      if (s_hs) begin
        e.pc    = req_addr;
        e.instr = mem_word(req_addr);
        e.fault = err_en && (req_addr == err_addr);
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (!rst_n) begin
      pc_r = 32'h0;
      pend = 1'b0;
      rsp_valid = 1'b0;
      sb.delete();
    end else if (env_on) begin
      if (s_pc_en) pc_r = s_pc_load ? s_pc_addr : pc_r + 32'd4;
      rsp_valid = 1'b0;
      rsp_err = 1'b0;
      if (s_hs) begin
        pend = 1'b1;
        pend_cnt = lat;
        pend_addr = s_req_addr;
      end
      if (pend) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          rsp_valid = 1'b1;
          rsp_data = mem_word(pend_addr);
          rsp_err = err_en && (pend_addr == err_addr);
          pend = 1'b0;
        end
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redirect = 1'b0;
    rdy = 1'b0;
    dec_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_err = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
    hs_cnt = 0;
    load_cnt = 0;
    dv_cnt = 0;
    first_hs_cyc = -1;
    first_dv_cyc = -1;
    req_log.delete();
    pop_log.delete();
    sb.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 1'b0, 32'h0,   1'b1};
    vecs[1] = '{1'b1, 1'b0, 32'h0,   32'h40,       1'b1, 1'b1, 1'b0, 32'h0,   1'b0};
    vecs[2] = '{1'b0, 1'b1, 32'h100, 32'h0,        1'b0, 1'b1, 1'b1, 32'h100, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 32'h200, 32'h10,       1'b0, 1'b1, 1'b1, 32'h200, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 32'h300, 32'h20,       1'b1, 1'b0, 1'b0, 32'h0,   1'b1};
    vecs[5] = '{1'b1, 1'b0, 32'h0,   32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0, 32'h0,   1'b0};

    // Reset with hostile inputs: every control output stays low.
    rst_n = 1'b0; redirect = 1'b1; rpc = 32'h123; rdy = 1'b1; dec_ready = 1'b1;
    rsp_valid = 1'b1; rsp_data = 32'hDEAD_BEEF; rsp_err = 1'b0; pc_r = 32'h44;
    cycle();
    cycle();
    check("rst_req_valid", 32'(s_req_valid), 0);
    check("rst_dec_valid", 32'(s_dec_valid), 0);
    check("rst_pc_en", 32'(s_pc_en), 0);
    check("rst_pc_load", 32'(s_pc_load), 0);
    check("rst_pc_addr", s_pc_addr, 0);

    // Table of single-cycle control vectors from a fresh REQ state.
    for (int i = 0; i < 6; i++) begin
      do_reset();
      rsp_valid = 1'b0;
      pc_r = vecs[i].pc;
      rdy = vecs[i].rdy;
      redirect = vecs[i].rd;
      rpc = vecs[i].rpc;
      cycle();
      check($sformatf("v%0d_req_valid", i), 32'(s_req_valid), 32'(vecs[i].e_valid));
      check($sformatf("v%0d_req_addr", i), s_req_addr, vecs[i].pc);
      check($sformatf("v%0d_pc_en", i), 32'(s_pc_en), 32'(vecs[i].e_en));
      check($sformatf("v%0d_pc_load", i), 32'(s_pc_load), 32'(vecs[i].e_load));
      check($sformatf("v%0d_pc_addr", i), s_pc_addr, vecs[i].e_paddr);
      rdy = 1'b0;
      redirect = 1'b0;
      cycle();
      check($sformatf("v%0d_next_valid", i), 32'(s_req_valid), 32'(vecs[i].e_next_valid));
    end

    env_on = 1'b1;

    // Streaming fetch with a 1-cycle memory.
    do_reset();
    lat = 1; rdy = 1'b1; dec_ready = 1'b1;
    cycle();
    check("a_first_req_valid", 32'(s_req_valid), 1);
    check("a_first_req_addr", s_req_addr, 0);
    for (int k = 0; k < 12; k++) cycle();
    check("a_req_count_ge3", 32'(req_log.size() >= 3), 1);
    check("a_req0", req_log[0], 32'h0);
    check("a_req1", req_log[1], 32'h4);
    check("a_req2", req_log[2], 32'h8);
    check("a_pop_count_ge3", 32'(pop_log.size() >= 3), 1);
    check("a_pop0", pop_log[0], 32'h0);
    check("a_pop1", pop_log[1], 32'h4);
    check("a_pop2", pop_log[2], 32'h8);
    check("a_latency", 32'(first_dv_cyc - first_hs_cyc), 2);

    // Decode stalled: exactly QDEPTH requests, then none until a pop.
    do_reset();
    lat = 1; rdy = 1'b1; dec_ready = 1'b0;
    for (int k = 0; k < 12; k++) cycle();
    check("b_hs_count", hs_cnt, QD);
    check("b_req_valid_full", 32'(s_req_valid), 0);
    dec_ready = 1'b1;
    cycle();
    check("b_req_valid_popcyc", 32'(s_req_valid), 0);
    dec_ready = 1'b0;
    cycle();
    check("b_req_valid_after_pop", 32'(s_req_valid), 1);
    check("b_req_addr_after_pop", s_req_addr, 32'h8);
    check("b_hs_count_after_pop", hs_cnt, QD + 1);

    // Redirect while waiting on a 3-cycle memory.
    do_reset();
    lat = 3; rdy = 1'b1; dec_ready = 1'b1;
    for (int k = 0; k < 5 && hs_cnt < 1; k++) cycle();
    check("c_first_hs", hs_cnt, 1);
    load_cnt = 0; dv_cnt = 0; pop_log.delete();
    redirect = 1'b1; rpc = 32'h100;
    cycle();
    redirect = 1'b0;
    check("c_rd_pc_load", 32'(s_pc_load), 1);
    check("c_rd_pc_en", 32'(s_pc_en), 1);
    check("c_rd_pc_addr", s_pc_addr, 32'h100);
    check("c_rd_req_valid", 32'(s_req_valid), 0);
    for (int k = 0; k < 10 && hs_cnt < 2; k++) cycle();
    check("c_second_hs", hs_cnt, 2);
    check("c_resume_addr", last_hs_addr, 32'h100);
    check("c_no_dec_valid", dv_cnt, 0);
    for (int k = 0; k < 6; k++) cycle();
    check("c_load_pulses", load_cnt, 1);
    check("c_pop_count", 32'(pop_log.size()), 1);
    check("c_pop0", pop_log[0], 32'h100);

    // Access fault at 0x8 halts fetch until a redirect.
    do_reset();
    lat = 1; rdy = 1'b1; dec_ready = 1'b1; err_en = 1'b1; err_addr = 32'h8;
    for (int k = 0; k < 20; k++) cycle();
    check("d_hs_count", hs_cnt, 3);
    check("d_fault_pc", last_pc, 32'h8);
    check("d_fault_bit", 32'(last_fault), 1);
    check("d_halted_req_valid", 32'(s_req_valid), 0);
    redirect = 1'b1; rpc = 32'h40;
    cycle();
    redirect = 1'b0;
    for (int k = 0; k < 5 && hs_cnt < 4; k++) cycle();
    check("d_resume_hs", hs_cnt, 4);
    check("d_resume_addr", last_hs_addr, 32'h40);
    err_en = 1'b0;

    // Redirect coinciding with pop and response at occupancy 1.
    do_reset();
    lat = 1; rdy = 1'b1; dec_ready = 1'b0;
    for (int k = 0; k < 10 && hs_cnt < 2; k++) cycle();
    check("e_setup_hs", hs_cnt, 2);
    dec_ready = 1'b1; redirect = 1'b1; rpc = 32'h80;
    cycle();
    redirect = 1'b0;
    check("e_occ1_dec_valid", 32'(s_dec_valid), 1);
    check("e_rsp_same_cycle", 32'(s_rsp_valid), 1);
    pop_log.delete();
    cycle();
    check("e_flushed_dec_valid", 32'(s_dec_valid), 0);
    check("e_req_valid", 32'(s_req_valid), 1);
    check("e_req_addr", s_req_addr, 32'h80);
    for (int k = 0; k < 6; k++) cycle();
    check("e_pop_count", 32'(pop_log.size()), 3);
    check("e_pop0", pop_log[0], 32'h80);

    // Memory not ready: request held stable, PC not stepped.
    do_reset();
    lat = 1; rdy = 1'b0; dec_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check($sformatf("f_hold%0d_valid", k), 32'(s_req_valid), 1);
      check($sformatf("f_hold%0d_addr", k), s_req_addr, 32'h0);
      check($sformatf("f_hold%0d_pc_en", k), 32'(s_pc_en), 0);
    end
    rdy = 1'b1;
    cycle();
    check("f_accept_pc_en", 32'(s_pc_en), 1);
    check("f_accept_hs", hs_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameters SHALL be: XLEN (default 32, address/instruction width); QDEPTH (default 2, fetch-queue entries, power of two, >=2).
REQ-002 Ports SHALL be:
  i_clk  in  1  clock
  i_rst_n  in  1  reset; synchronous, active-low
  i_pc  in  XLEN  current PC from the PC counter
  o_pc_en  out  1  PC counter enable
  o_pc_load  out  1  PC counter load (1 = load o_pc_addr, 0 = step)
  o_pc_addr  out  XLEN  PC load value
  o_mem_req_valid  out  1  instruction-memory request valid
  i_mem_req_ready  in  1  memory accepts request
  o_mem_req_addr  out  XLEN  request address
  i_mem_rsp_valid  in  1  response valid (no backpressure)
  i_mem_rsp_data  in  XLEN  instruction word
  i_mem_rsp_err  in  1  access fault
  o_dec_valid  out  1  queue head valid to decode
  i_dec_ready  in  1  decode accepts head
  o_dec_instr  out  XLEN  head instruction
  o_dec_pc  out  XLEN  head PC
  o_dec_fault  out  1  head carries access fault
  i_redirect  in  1  branch/trap redirect pulse
  i_redirect_pc  in  XLEN  redirect target

Function
REQ-003 FSM states SHALL be REQ, WAIT, DRAIN, HALT; at most one memory request outstanding.
REQ-004 REQ: o_mem_req_valid SHALL be 1 iff queue occupancy < QDEPTH and no redirect this cycle; o_mem_req_addr = i_pc.
REQ-005 Request handshake (valid & ready) SHALL latch i_pc as the outstanding PC, pulse o_pc_en=1/o_pc_load=0 the same cycle, and go to WAIT.
REQ-006 o_mem_req_valid, once asserted, SHALL hold with stable address until handshake or redirect.
REQ-007 WAIT: i_mem_rsp_valid SHALL push {outstanding PC, data, err} into the queue; err=0 -> REQ, err=1 -> HALT.
REQ-008 A response with i_mem_rsp_valid in REQ or HALT SHALL be ignored.
REQ-009 HALT: no requests SHALL be issued until i_redirect.
REQ-010 i_redirect SHALL, in any state: drive o_pc_en=1, o_pc_load=1, o_pc_addr=i_redirect_pc that cycle; flush the queue (occupancy 0 next cycle); suppress o_mem_req_valid that cycle.
REQ-011 Redirect target next state: WAIT -> DRAIN, or WAIT with i_mem_rsp_valid that same cycle -> REQ (response discarded); REQ, HALT, DRAIN-with-response -> REQ; DRAIN without response -> DRAIN.
REQ-012 DRAIN: the arriving response SHALL be discarded and the FSM SHALL go to REQ; no requests in DRAIN.
REQ-013 When not redirecting, o_pc_load SHALL be 0 and o_pc_addr SHALL be 0.
REQ-014 Queue SHALL be a FIFO; o_dec_valid = occupancy != 0; head pops on o_dec_valid & i_dec_ready.
REQ-015 Simultaneous push and pop at full occupancy SHALL be impossible by REQ-004 (space reserved at issue); push and pop in the same cycle at other occupancies SHALL keep occupancy unchanged.
REQ-016 Redirect SHALL override a same-cycle pop and push (queue ends empty).
REQ-017 Request-to-o_dec_valid latency SHALL be 1 cycle after response (response registered into queue).
REQ-018 Pointers SHALL wrap modulo QDEPTH; occupancy counter is clog2(QDEPTH)+1 bits.

Reset
REQ-019 While i_rst_n=0: state REQ, occupancy 0, pointers 0, outstanding PC 0; o_mem_req_valid, o_dec_valid, o_pc_en, o_pc_load = 0; o_pc_addr = 0.
REQ-020 Reset asserted mid-WAIT SHALL abandon the outstanding request; the first post-reset response is the memory's responsibility to suppress.
REQ-021 First request SHALL issue in the first cycle after reset deassertion, address i_pc.

Structure
REQ-022 Package fetch_pkg SHALL hold the FSM state enum and the queue entry struct {pc, instr, fault}.
REQ-023 The queue SHALL be a sub-module fetch_queue (parameterized on entry type width and QDEPTH, with flush).
REQ-024 fetch_unit SHALL instantiate counter-compatible PC control only via ports; it does not contain the PC register.

Verification
REQ-025 Reset release, ready=1, 1-cycle memory, i_dec_ready=1: requests to 0x0, 0x4, 0x8; o_dec_pc sequence 0x0, 0x4, 0x8 in order.
REQ-026 i_dec_ready=0: exactly QDEPTH requests issued, then o_mem_req_valid=0 until a pop.
REQ-027 Redirect to 0x100 while WAIT: late response discarded, queue empty, next o_mem_req_addr=0x100, o_pc_load pulsed once.
REQ-028 Response with err=1 at 0x8: entry fault=1 at o_dec_pc=0x8, no further requests until redirect to 0x40 resumes at 0x40.
REQ-029 Redirect same cycle as pop and response at occupancy 1: occupancy 0 next cycle, no stale entry reaches decode.
REQ-030 i_mem_req_ready held 0 for 5 cycles: o_mem_req_valid and address 0x0 stable, o_pc_en=0 throughout.
